// File: rtl/resp_cmp_pkg.sv
// Shared types and helpers for the response MISR collector and its software-model cross-check.
package resp_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_COLLECT,
    ST_DRAIN
  } state_t;

  localparam logic [31:0] POLY_DEFAULT = 32'h04C11DB7;
  localparam logic [31:0] SEED_DEFAULT = 32'hFFFFFFFF;

  // Widest response bus fold_xor accepts; narrower buses are zero-extended by the caller.
  localparam int FOLD_MAX_W = 256;

  function automatic logic [31:0] fold_xor(input logic [FOLD_MAX_W-1:0] data);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < FOLD_MAX_W / 32; k++) begin
      acc = acc ^ data[32*k +: 32];
    end
    return acc;
  endfunction

endpackage

// File: rtl/misr32_step.sv
// One MISR step: fold the response bus to 32 bits, then shift with polynomial feedback.
module misr32_step
  import resp_cmp_pkg::*;
#(
  parameter int          OUT_W = 159,
  parameter logic [31:0] POLY  = POLY_DEFAULT
) (
  input  logic [31:0]      sig,
  input  logic [OUT_W-1:0] data,
  output logic [31:0]      sig_next
);

  logic [FOLD_MAX_W-1:0] data_ext;
  logic [31:0]           fold;

  assign data_ext = FOLD_MAX_W'(data);
  assign fold     = fold_xor(data_ext);
  assign sig_next = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ fold;

endmodule

// File: rtl/resp_misr_collector.sv
// Compacts a programmed window of out_flat samples into a 32-bit MISR signature and
// reads out {signature, sample count} as a two-word valid/ready stream.
module resp_misr_collector
  import resp_cmp_pkg::*;
#(
  parameter int                OUT_W = 159,
  parameter int                SIG_W = 32,
  parameter int                CNT_W = 16,
  parameter logic [SIG_W-1:0]  POLY  = POLY_DEFAULT,
  parameter logic [SIG_W-1:0]  SEED  = SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] skip_cyc,
  input  logic [CNT_W-1:0] num_cyc,
  input  logic [OUT_W-1:0] out_flat,
  output logic             busy,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [SIG_W-1:0] rd_data,
  output logic             rd_last,
  output logic             done
);

  state_t             state;
  state_t             state_nxt;
  logic [SIG_W-1:0]   sig;
  logic [SIG_W-1:0]   sig_next;
  logic [CNT_W-1:0]   skip_left;
  logic [CNT_W-1:0]   coll_left;
  logic [CNT_W-1:0]   sample_cnt;
  logic               word_sel;

  misr32_step #(
    .OUT_W (OUT_W),
    .POLY  (POLY)
  ) u_step (
    .sig      (sig),
    .data     (out_flat),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    rd_data   = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (skip_cyc != '0)     state_nxt = ST_SKIP;
          else if (num_cyc != '0) state_nxt = ST_COLLECT;
          else                    state_nxt = ST_DRAIN;
        end
      end
      ST_SKIP: begin
        busy = 1'b1;
        if (skip_left == CNT_W'(1)) state_nxt = (coll_left != '0) ? ST_COLLECT : ST_DRAIN;
      end
      ST_COLLECT: begin
        busy = 1'b1;
        if (coll_left == CNT_W'(1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy     = 1'b1;
        rd_valid = 1'b1;
        rd_last  = word_sel;
        rd_data  = word_sel ? SIG_W'(sample_cnt) : sig;
        if (word_sel && rd_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // skip_left / coll_left double as the latched skip_cyc / num_cyc, counted down to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig        <= SEED;
      skip_left  <= '0;
      coll_left  <= '0;
      sample_cnt <= '0;
      word_sel   <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sig        <= SEED;
            skip_left  <= skip_cyc;
            coll_left  <= num_cyc;
            sample_cnt <= '0;
            word_sel   <= 1'b0;
            done       <= 1'b0;
          end
        end
        ST_SKIP: skip_left <= skip_left - CNT_W'(1);
        ST_COLLECT: begin
          sig        <= sig_next;
          sample_cnt <= sample_cnt + CNT_W'(1);
          coll_left  <= coll_left - CNT_W'(1);
        end
        ST_DRAIN: begin
          if (rd_ready) begin
            if (word_sel) begin
              done     <= 1'b1;
              word_sel <= 1'b0;
            end else begin
              word_sel <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_resp_misr_collector.sv
// Directed bench for resp_misr_collector: vector table plus multi-cycle corner sequences.
module tb_resp_misr_collector;

  localparam int OUT_W = 159;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [15:0]      skip_cyc;
  logic [15:0]      num_cyc;
  logic [OUT_W-1:0] out_flat;
  logic             busy;
  logic             rd_valid;
  logic             rd_ready;
  logic [31:0]      rd_data;
  logic             rd_last;
  logic             done;

  resp_misr_collector dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .skip_cyc (skip_cyc),
    .num_cyc  (num_cyc),
    .out_flat (out_flat),
    .busy     (busy),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Bitwise fold model: bit i of the bus lands on bit i%32.
  function automatic logic [31:0] m_fold(input logic [OUT_W-1:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < OUT_W; i++) r[i % 32] = r[i % 32] ^ d[i];
    return r;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [OUT_W-1:0] d);
    logic [31:0] fb;
    fb = s[31] ? 32'h04C11DB7 : 32'h0;
    return {s[30:0], 1'b0} ^ fb ^ m_fold(d);
  endfunction

  function automatic logic [OUT_W-1:0] pat(input int j);
    logic [159:0] t;
    for (int k = 0; k < 5; k++)
      t[32*k +: 32] = 32'(j) * 32'h9E3779B9 + 32'(k) * 32'h7F4A7C15 + 32'h13579BDF;
    return t[OUT_W-1:0];
  endfunction

  typedef struct {
    string            name;
    logic [15:0]      skip;
    logic [15:0]      num;
    logic [OUT_W-1:0] data;
    logic [31:0]      w0;
    logic [31:0]      w1;
  } vec_t;

  // Drives a start with constant out_flat, rd_ready high, and checks latency, both words and done.
  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    skip_cyc = v.skip;
    num_cyc  = v.num;
    out_flat = v.data;
    rd_ready = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!rd_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({v.name, " latency"}, 32'(n), 32'(v.skip) + 32'(v.num) + 32'd1);
    check({v.name, " busy"}, 32'(busy), 32'd1);
    check({v.name, " w0"}, rd_data, v.w0);
    check({v.name, " w0 last"}, 32'(rd_last), 32'd0);
    @(negedge clk);
    check({v.name, " w1"}, rd_data, v.w1);
    check({v.name, " w1 last"}, 32'(rd_last), 32'd1);
    @(negedge clk);
    check({v.name, " done"}, 32'(done), 32'd1);
    check({v.name, " idle valid"}, 32'(rd_valid), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [31:0]      exp_sig;
    logic [OUT_W-1:0] two_bits;

    two_bits = '0;
    two_bits[0]   = 1'b1;
    two_bits[128] = 1'b1;

    vecs[0] = '{"s0n1_zero",   16'd0, 16'd1, '0,                32'hFB3EE249, 32'h1};
    vecs[1] = '{"s0n1_one",    16'd0, 16'd1, OUT_W'(1),         32'hFB3EE248, 32'h1};
    vecs[2] = '{"s0n1_cancel", 16'd0, 16'd1, two_bits,          32'hFB3EE249, 32'h1};
    vecs[3] = '{"s0n0",        16'd0, 16'd0, OUT_W'(5),         32'hFFFFFFFF, 32'h0};
    vecs[4] = '{"s3n1_zero",   16'd3, 16'd1, '0,                32'hFB3EE249, 32'h1};
    vecs[5] = '{"s0n2_zero",   16'd0, 16'd2, '0,                32'hF2BCD925, 32'h2};

    rst_n    = 1'b0;
    start    = 1'b0;
    skip_cyc = '0;
    num_cyc  = '0;
    out_flat = '0;
    rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst valid", 32'(rd_valid), 32'd0);
    check("rst data", rd_data, 32'd0);
    check("rst last", 32'(rd_last), 32'd0);
    check("rst done", 32'(done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // skip=2 num=3 with a changing bus, then backpressure for 4 cycles
    @(negedge clk);
    skip_cyc = 16'd2;
    num_cyc  = 16'd3;
    rd_ready = 1'b0;
    out_flat = pat(0);
    start    = 1'b1;
    exp_sig  = SEED;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j <= 2) check("skip busy", 32'(busy), 32'd1);
      check("window valid", 32'(rd_valid), 32'd0);
      out_flat = pat(j);
      if (j >= 3) exp_sig = m_step(exp_sig, pat(j));
    end
    @(negedge clk);
    out_flat = pat(6);
    check("win valid", 32'(rd_valid), 32'd1);
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      out_flat = pat(7 + h);
      check("hold valid", 32'(rd_valid), 32'd1);
      check("hold w0", rd_data, exp_sig);
      check("hold last", 32'(rd_last), 32'd0);
    end
    rd_ready = 1'b1;
    @(negedge clk);
    check("win w1", rd_data, 32'd3);
    check("win w1 last", 32'(rd_last), 32'd1);
    @(negedge clk);
    check("win done", 32'(done), 32'd1);

    // start pulse mid-COLLECT and on word-1 acceptance are both ignored
    @(negedge clk);
    skip_cyc = 16'd0;
    num_cyc  = 16'd10;
    out_flat = pat(0);
    start    = 1'b1;
    exp_sig  = SEED;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      start = (j == 4);
      if (j == 4) begin
        skip_cyc = 16'd0;
        num_cyc  = 16'd1;
      end
      out_flat = pat(j);
      exp_sig  = m_step(exp_sig, pat(j));
    end
    @(negedge clk);
    start = 1'b0;
    check("ign done cleared", 32'(done), 32'd0);
    check("ign w0", rd_data, exp_sig);
    @(negedge clk);
    check("ign w1", rd_data, 32'd10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign acc busy", 32'(busy), 32'd0);
    check("ign acc done", 32'(done), 32'd1);
    @(negedge clk);
    check("ign acc still idle", 32'(busy), 32'd0);

    // reset mid-COLLECT
    skip_cyc = 16'd0;
    num_cyc  = 16'd20;
    out_flat = OUT_W'(1);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-rst busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst valid", 32'(rd_valid), 32'd0);
    check("mid rst data", rd_data, 32'd0);
    check("mid rst last", 32'(rd_last), 32'd0);
    check("mid rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
